// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI master transfer controller.
// Holds the controller state encoding and default widths.
package spi_master_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int LEN_WIDTH_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TX_FETCH,
        ST_TX_SHIFT,
        ST_RX_SHIFT,
        ST_RX_PUSH,
        ST_DONE
    } state_e;

endpackage

// File: rtl/spi_master_xfer_ctrl_if.sv
// FIFO and shift-engine bundle around the SPI transfer controller.
// master = controller side, slave = FIFO/shift-engine side.
interface spi_master_xfer_ctrl_if
    import spi_master_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int SW         = $clog2(DATA_WIDTH)
);

    logic [DATA_WIDTH-1:0] txf_data;
    logic                  txf_valid;
    logic                  txf_ready;
    logic [DATA_WIDTH-1:0] rxf_data;
    logic                  rxf_valid;
    logic                  rxf_ready;
    logic                  sh_start;
    logic                  sh_rx;
    logic [SW:0]           sh_len;
    logic [DATA_WIDTH-1:0] sh_tdata;
    logic [DATA_WIDTH-1:0] sh_rdata;
    logic                  sh_done;

    modport master (
        input  txf_data, txf_valid, rxf_ready, sh_rdata, sh_done,
        output txf_ready, rxf_data, rxf_valid,
        output sh_start, sh_rx, sh_len, sh_tdata
    );

    modport slave (
        output txf_data, txf_valid, rxf_ready, sh_rdata, sh_done,
        input  txf_ready, rxf_data, rxf_valid,
        input  sh_start, sh_rx, sh_len, sh_tdata
    );

endinterface

// File: rtl/spi_xfer_wcnt.sv
// Per-phase word counter: words left in the phase and the
// bit length of the word currently being moved.
module spi_xfer_wcnt
    import spi_master_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int LEN_WIDTH  = LEN_WIDTH_DEF,
    localparam int SW         = $clog2(DATA_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic                 adv,
    output logic                 nz,
    output logic                 last,
    output logic [SW:0]          word_len
);

    localparam logic [SW:0] FULL = (SW + 1)'(DATA_WIDTH);

    logic [LEN_WIDTH-1:0] cnt;
    logic [SW-1:0]        rem;
    logic [LEN_WIDTH-1:0] words;

    // ceil(len / DATA_WIDTH); the shift leaves headroom so the
    // round-up add cannot wrap even at the maximum length
    assign words = (len >> SW) + LEN_WIDTH'(|len[SW-1:0]);

    // words remaining, including the one in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            rem <= '0;
        end else if (load) begin
            cnt <= words;
            rem <= len[SW-1:0];
        end else if (adv && cnt != '0) begin
            cnt <= cnt - LEN_WIDTH'(1);
        end
    end

    // last word carries the remainder, all others are full width
    always_comb begin
        nz       = (cnt != '0);
        last     = (cnt == LEN_WIDTH'(1));
        word_len = FULL;
        if (last && rem != '0) begin
            word_len = {1'b0, rem};
        end
    end

endmodule

// File: rtl/spi_master_xfer_ctrl.sv
// SPI master transfer controller: sequences a TX phase then an
// RX phase of FIFO words through a word-level shift engine.
module spi_master_xfer_ctrl
    import spi_master_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int LEN_WIDTH  = LEN_WIDTH_DEF,
    localparam int SW         = $clog2(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [LEN_WIDTH-1:0]  tx_len_i,
    input  logic [LEN_WIDTH-1:0]  rx_len_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic [DATA_WIDTH-1:0] txf_data_i,
    input  logic                  txf_valid_i,
    output logic                  txf_ready_o,
    output logic [DATA_WIDTH-1:0] rxf_data_o,
    output logic                  rxf_valid_o,
    input  logic                  rxf_ready_i,
    output logic                  sh_start_o,
    output logic                  sh_rx_o,
    output logic [SW:0]           sh_len_o,
    output logic [DATA_WIDTH-1:0] sh_data_o,
    input  logic [DATA_WIDTH-1:0] sh_data_i,
    input  logic                  sh_done_i
);

    state_e      state;
    state_e      state_n;
    logic        load;
    logic        tx_adv;
    logic        rx_adv;
    logic        tx_nz;
    logic        tx_last;
    logic        rx_nz;
    logic        rx_last;
    logic [SW:0] tx_wlen;
    logic [SW:0] rx_wlen;

    assign load   = (state == ST_IDLE) && start_i && !abort_i;
    assign tx_adv = (state == ST_TX_SHIFT) && sh_done_i && !abort_i;
    assign rx_adv = (state == ST_RX_PUSH) && rxf_ready_i && !abort_i;

    spi_xfer_wcnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_tx_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (load),
        .len      (tx_len_i),
        .adv      (tx_adv),
        .nz       (tx_nz),
        .last     (tx_last),
        .word_len (tx_wlen)
    );

    spi_xfer_wcnt #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_rx_cnt (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .load     (load),
        .len      (rx_len_i),
        .adv      (rx_adv),
        .nz       (rx_nz),
        .last     (rx_last),
        .word_len (rx_wlen)
    );

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next state and state-decoded outputs; abort overrides all
    always_comb begin
        state_n     = state;
        busy_o      = (state != ST_IDLE);
        done_o      = (state == ST_DONE);
        txf_ready_o = (state == ST_TX_FETCH);
        rxf_valid_o = (state == ST_RX_PUSH);
        sh_rx_o     = 1'b0;
        sh_len_o    = '0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    if (tx_len_i != '0) begin
                        state_n = ST_TX_FETCH;
                    end else if (rx_len_i != '0) begin
                        state_n = ST_RX_SHIFT;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_TX_FETCH: begin
                sh_len_o = tx_wlen;
                if (txf_valid_i) begin
                    state_n = ST_TX_SHIFT;
                end
            end
            ST_TX_SHIFT: begin
                sh_len_o = tx_wlen;
                if (sh_done_i) begin
                    if (tx_nz && !tx_last) begin
                        state_n = ST_TX_FETCH;
                    end else if (rx_nz) begin
                        state_n = ST_RX_SHIFT;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
            end
            ST_RX_SHIFT: begin
                sh_rx_o  = 1'b1;
                sh_len_o = rx_wlen;
                if (sh_done_i) begin
                    state_n = ST_RX_PUSH;
                end
            end
            ST_RX_PUSH: begin
                sh_rx_o  = 1'b1;
                sh_len_o = rx_wlen;
                if (rxf_ready_i) begin
                    state_n = (rx_nz && !rx_last) ? ST_RX_SHIFT : ST_DONE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_n = ST_IDLE;
        end
    end

    // start pulse marks entry into a shift state, not the stay
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_start_o <= 1'b0;
        end else begin
            sh_start_o <= (state_n == ST_TX_SHIFT ||
                           state_n == ST_RX_SHIFT) &&
                          (state_n != state);
        end
    end

    // one data word held per direction
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sh_data_o  <= '0;
            rxf_data_o <= '0;
        end else begin
            if (txf_ready_o && txf_valid_i && !abort_i) begin
                sh_data_o <= txf_data_i;
            end
            if (state == ST_RX_SHIFT && sh_done_i && !abort_i) begin
                rxf_data_o <= sh_data_i;
            end
        end
    end

endmodule
